// File: rtl/capture_pkg.sv
// capture_pkg
//   Shared definitions for the sample capture block: default sample and
//   address widths, and the capture FSM state encoding.
package capture_pkg;

  localparam int DW_DEFAULT = 20;  // signed sample width
  localparam int AW_DEFAULT = 10;  // buffer address width (depth 2**AW)

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/sample_ram.sv
// sample_ram
//   Single-clock simple dual-port RAM, 2**AW words of DW bits.
//   One write port, one read port with a registered output (latency 1).
//   Contents are not initialised and are not touched by any reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata updates on the next edge only when set
//   raddr  in   read address
//   rdata  out  registered read data
module sample_ram
  import capture_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl
//   Arms on start, then writes the next len valid filter samples into a
//   2**AW-deep buffer starting at address 0, and stops in DONE. The buffer
//   can be read back (latency 1) while idle or done.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   arm a capture (accepted in IDLE or DONE only)
//   abort      in   cancel, return to IDLE; highest priority
//   len        in   capture length, latched on accepted start; 0 = 2**AW
//   din_valid  in   sample strobe
//   din        in   signed sample
//   rd_en      in   readback request (honoured in IDLE or DONE only)
//   rd_addr    in   readback address
//   rd_data    out  readback data, holds its value when rd_valid=0
//   rd_valid   out  readback strobe, one cycle after an honoured rd_en
//   busy       out  high in ARMED or CAPTURE
//   done       out  high in DONE
//   wr_count   out  samples written in the current or last capture
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   len,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   wr_count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  cap_state_t    state_reg, state_next;
  logic [AW:0]   len_reg, len_next;
  logic [AW:0]   count_reg, count_next;
  logic [AW-1:0] waddr_reg, waddr_next;
  logic          wr_en;
  logic [AW:0]   len_eff;

  logic          rd_accept;
  logic          rd_valid_reg;
  logic [DW-1:0] hold_reg;
  logic [DW-1:0] ram_q;

  // 0 selects a full buffer. Lengths beyond the depth are clamped so the
  // write address can never wrap inside one capture.
  assign len_eff = (len == '0 || len > DEPTH) ? DEPTH : len;

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    count_next = count_reg;
    waddr_next = waddr_reg;
    wr_en      = 1'b0;
    if (abort) begin
      // counters and buffer are left as they are for post-mortem readback
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next = ST_ARMED;
            len_next   = len_eff;
            count_next = '0;
            waddr_next = '0;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          if (din_valid) begin
            wr_en      = 1'b1;
            count_next = count_reg + 1'b1;
            waddr_next = waddr_reg + 1'b1;
            state_next = (count_next == len_reg) ? ST_DONE : ST_CAPTURE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      len_reg   <= DEPTH;
      count_reg <= '0;
      waddr_reg <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      waddr_reg <= waddr_next;
    end
  end

  // Readback is only served while no capture is writing the buffer.
  assign rd_accept = rd_en && (state_reg == ST_IDLE || state_reg == ST_DONE);

  // The RAM output register has no reset; rd_data is muxed with a
  // resettable copy so it reads 0 after reset and holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      hold_reg     <= '0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_valid_reg) begin
        hold_reg <= ram_q;
      end
    end
  end

  sample_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en & rst_n),
    .waddr (waddr_reg),
    .wdata (din),
    .re    (rd_accept),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign rd_data  = rd_valid_reg ? ram_q : hold_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
  assign done     = (state_reg == ST_DONE);
  assign wr_count = count_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl
//   Self-checking bench for capture_ctrl. Inputs change on the falling edge;
//   status outputs are checked on the falling edge; readback results are
//   checked by a monitor 1 time unit after each rising edge against a
//   queue of expectations pushed when the read request is driven.
module tb_capture_ctrl;

  localparam int DW = 20;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW:0]   len;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            valid;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       rd_q[$];
  rd_exp_t       rd_e;
  logic [DW-1:0] exp_last = '0;
  logic [DW-1:0] model_mem [0:(1<<AW)-1];

  capture_ctrl #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .len       (len),
    .din_valid (din_valid),
    .din       (din),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // readback monitor
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      exp_last = '0;
      rd_q.delete();
      check_eq("rst_rd_valid", 32'(rd_valid), 32'(0));
      check_eq("rst_rd_data", 32'(rd_data), 32'(0));
    end else if (rd_q.size() > 0) begin
      rd_e = rd_q.pop_front();
      check_eq("rd_valid", 32'(rd_valid), 32'(rd_e.valid));
      if (rd_e.valid) begin
        check_eq("rd_data", 32'(rd_data), 32'(rd_e.data));
        $display("read: valid=%0d data=%0d expected %0d", rd_valid, rd_data, rd_e.data);
        exp_last = rd_e.data;
      end else begin
        check_eq("rd_hold", 32'(rd_data), 32'(exp_last));
        $display("read ignored: valid=%0d data=%0d", rd_valid, rd_data);
      end
    end else begin
      check_eq("rd_idle_valid", 32'(rd_valid), 32'(0));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = n[AW:0];
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int d);
    din_valid = 1'b1;
    din       = DW'(d);
    step();
    din_valid = 1'b0;
  endtask

  task automatic rd(input int a, input bit exp_valid);
    rd_en   = 1'b1;
    rd_addr = a[AW-1:0];
    rd_q.push_back('{valid: exp_valid, data: model_mem[a]});
    step();
    rd_en = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit b, input bit d, input int wc);
    check_eq({tag, "_busy"}, 32'(busy), 32'(b));
    check_eq({tag, "_done"}, 32'(done), 32'(d));
    check_eq({tag, "_wr_count"}, 32'(wr_count), 32'(wc));
    $display("%s: busy=%0d done=%0d wr_count=%0d", tag, busy, done, wr_count);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0;
    din_valid = 1'b0; din = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) step();
    check_status("reset", 0, 0, 0);
    rst_n = 1'b1;
    step();

    // warm-up capture of 8 known values so unwritten words are predictable
    do_start(8);
    for (int i = 0; i < 10; i++) feed(100 + i);
    for (int i = 0; i < 8; i++) model_mem[i] = DW'(100 + i);
    check_status("warmup", 0, 1, 8);

    // len=4, six valid samples 1..6
    do_start(4);
    check_status("len4_armed", 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      feed(i);
      if (i == 4) check_status("len4_fill", 0, 1, 4);
    end
    for (int i = 0; i < 4; i++) model_mem[i] = DW'(i + 1);
    check_status("len4_end", 0, 1, 4);
    for (int a = 0; a < 6; a++) rd(a, 1'b1);

    // len=8 with din_valid toggling: done after 15 active cycles
    do_start(8);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) check_eq("toggle_not_done", 32'(done), 32'(0));
      din_valid = (c % 2 == 0);
      din       = DW'(200 + c / 2);
      if (c == 7) begin
        rd_en   = 1'b1;
        rd_addr = '0;
        rd_q.push_back('{valid: 1'b0, data: '0});
      end
      step();
      rd_en     = 1'b0;
      din_valid = 1'b0;
    end
    for (int k = 0; k < 8; k++) model_mem[k] = DW'(200 + k);
    check_status("toggle_end", 0, 1, 8);
    for (int a = 0; a < 8; a++) rd(a, 1'b1);

    // abort after 3 samples; the abort-cycle sample must not be written
    do_start(8);
    feed(300); feed(301); feed(302);
    for (int k = 0; k < 3; k++) model_mem[k] = DW'(300 + k);
    abort = 1'b1; din_valid = 1'b1; din = DW'(999);
    step();
    abort = 1'b0; din_valid = 1'b0;
    check_status("abort", 0, 0, 3);
    start = 1'b1; abort = 1'b1; len = 11'd2;
    step();
    start = 1'b0; abort = 1'b0;
    check_status("start_abort", 0, 0, 3);
    rd(3, 1'b1);
    do_start(2);
    check_status("restart_armed", 1, 0, 0);
    feed(400); feed(401);
    model_mem[0] = DW'(400); model_mem[1] = DW'(401);
    check_status("restart_end", 0, 1, 2);
    for (int a = 0; a < 3; a++) rd(a, 1'b1);

    // start while busy is ignored, len not re-latched
    do_start(4);
    feed(500);
    start = 1'b1; len = 11'd2; din_valid = 1'b1; din = DW'(501);
    step();
    start = 1'b0; din_valid = 1'b0;
    check_status("busy_start", 1, 0, 2);
    feed(502);
    check_status("busy_start3", 1, 0, 3);
    feed(503);
    check_status("busy_start4", 0, 1, 4);
    for (int k = 0; k < 4; k++) model_mem[k] = DW'(500 + k);

    // reset mid-capture with din_valid high suppresses the write
    do_start(4);
    feed(600);
    model_mem[0] = DW'(600);
    rst_n = 1'b0; din_valid = 1'b1; din = DW'(601);
    step();
    check_status("mid_reset", 0, 0, 0);
    rst_n = 1'b1; din_valid = 1'b0;
    step();
    rd(0, 1'b1);
    rd(1, 1'b1);

    // len=0: full 1024-sample capture, no wrap onto address 0
    do_start(0);
    for (int i = 0; i < 1030; i++) begin
      din_valid = 1'b1;
      din       = DW'(1000 + i);
      step();
      if (i == 1022) check_status("full_1023", 1, 0, 1023);
    end
    din_valid = 1'b0;
    for (int i = 0; i < 1024; i++) model_mem[i] = DW'(1000 + i);
    check_status("full_end", 0, 1, 1024);
    rd(0, 1'b1);
    rd(1, 1'b1);
    rd(512, 1'b1);
    rd(1023, 1'b1);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
